// File: rtl/soc_addr_map_cfg_pkg.sv
// Shared SoC address-map types: rule entry layout, table sizing and the reset-time rule table.
package soc_addr_map_cfg_pkg;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned NrRules   = 11;
  localparam int unsigned NrSlaves  = 11;
  localparam int unsigned IdxW      = (NrSlaves > 1) ? $clog2(NrSlaves) : 1;
  localparam int unsigned CntW      = 32;

  typedef struct packed {
    logic                 en;
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] len;
    logic [IdxW-1:0]      idx;
  } rule_t;

  typedef rule_t [NrRules-1:0] rule_tbl_t;

  // SoC memory map seen by the crossbar after reset
  localparam logic [AddrWidth-1:0] DramBase = 64'h0000_0000_8000_0000;
  localparam logic [AddrWidth-1:0] DramLen  = 64'h0000_0000_4000_0000;
  localparam logic [IdxW-1:0]      DramIdx  = IdxW'(1);
  localparam logic [AddrWidth-1:0] UartBase = 64'h0000_0000_1000_0000;
  localparam logic [AddrWidth-1:0] UartLen  = 64'h0000_0000_0000_1000;
  localparam logic [IdxW-1:0]      UartIdx  = IdxW'(2);
  localparam logic [AddrWidth-1:0] RomBase  = 64'h0000_0000_0200_0000;
  localparam logic [AddrWidth-1:0] RomLen   = 64'h0000_0000_0001_0000;
  localparam logic [IdxW-1:0]      RomIdx   = IdxW'(3);

  function automatic rule_tbl_t soc_rst_rules();
    rule_tbl_t tbl;
    tbl    = '0;
    tbl[0] = '{en: 1'b1, base: DramBase, len: DramLen, idx: DramIdx};
    tbl[1] = '{en: 1'b1, base: UartBase, len: UartLen, idx: UartIdx};
    tbl[2] = '{en: 1'b1, base: RomBase,  len: RomLen,  idx: RomIdx};
    return tbl;
  endfunction

  localparam rule_tbl_t RstRulesDefault = soc_rst_rules();

endpackage

// File: rtl/soc_addr_map_cfg_if.sv
// Lookup request/response channel between the address-routing logic and the decoder.
interface soc_addr_map_cfg_if;
  import soc_addr_map_cfg_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IdxW-1:0]      rsp_idx;
  logic                 rsp_hit;
  logic                 rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_idx, rsp_hit, rsp_err
  );

endinterface

// File: rtl/soc_addr_rule_match.sv
// Single-rule comparator: does i_addr fall inside [base, base+len) of an enabled, well-formed rule.
module soc_addr_rule_match
  import soc_addr_map_cfg_pkg::*;
#(
  parameter int unsigned NrSlaves = soc_addr_map_cfg_pkg::NrSlaves
) (
  input  rule_t                i_rule,
  input  logic [AddrWidth-1:0] i_addr,
  output logic                 o_match_c
);

  // One extra bit so a region ending exactly at the top of the address space does not wrap
  logic [AddrWidth:0] w_end;
  logic               w_idx_ok;

  assign w_end     = {1'b0, i_rule.base} + {1'b0, i_rule.len};
  assign w_idx_ok  = 32'(i_rule.idx) < NrSlaves;
  assign o_match_c = i_rule.en && (i_rule.len != '0) && w_idx_ok &&
                     (i_addr >= i_rule.base) && ({1'b0, i_addr} < w_end);

endmodule

// File: rtl/soc_addr_map_cfg.sv
// Run-time programmable address decoder: writable rule table, lock, registered lookup result, miss counter.
module soc_addr_map_cfg
  import soc_addr_map_cfg_pkg::*;
#(
  parameter int unsigned         NrRules    = soc_addr_map_cfg_pkg::NrRules,
  parameter int unsigned         NrSlaves   = soc_addr_map_cfg_pkg::NrSlaves,
  parameter bit                  EnDefault  = 1'b1,
  parameter int unsigned         DefaultIdx = 0,
  parameter rule_t [NrRules-1:0] RstRules   = '0,
  localparam int unsigned        CfgAddrW   = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_we_i,
  input  logic [CfgAddrW-1:0] cfg_addr_i,
  input  rule_t               cfg_rule_i,
  input  logic                cfg_lock_i,
  output logic                cfg_err_o,
  output logic                locked_o,
  output logic [CntW-1:0]     miss_cnt_o,
  soc_addr_map_cfg_if.slave   lookup
);

  rule_t [NrRules-1:0] r_rules;
  logic                r_locked;
  logic                r_cfg_err;
  logic                r_rsp_valid;
  logic [IdxW-1:0]     r_rsp_idx;
  logic                r_rsp_hit;
  logic                r_rsp_err;
  logic [CntW-1:0]     r_miss_cnt;

  logic [NrRules-1:0]  w_match;
  logic                w_hit;
  logic [IdxW-1:0]     w_hit_idx;
  logic [IdxW-1:0]     w_miss_idx;
  logic                w_req_ready;
  logic                w_accept;
  logic                w_cfg_reject;
  logic [CntW-1:0]     w_miss_cnt_nxt;

  for (genvar g = 0; g < NrRules; g++) begin : g_match
    soc_addr_rule_match #(
      .NrSlaves (NrSlaves)
    ) u_match (
      .i_rule    (r_rules[g]),
      .i_addr    (lookup.req_addr),
      .o_match_c (w_match[g])
    );
  end

  // Lowest matching entry wins
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < NrRules; i++) begin
      if (w_match[i] && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_idx = r_rules[i].idx;
      end
    end
  end

  assign w_miss_idx     = EnDefault ? IdxW'(DefaultIdx) : '0;
  assign w_req_ready    = !r_rsp_valid || lookup.rsp_ready;
  assign w_accept       = lookup.req_valid && w_req_ready;
  assign w_cfg_reject   = r_locked || (32'(cfg_addr_i) >= NrRules);
  assign w_miss_cnt_nxt = (r_miss_cnt == '1) ? r_miss_cnt : r_miss_cnt + CntW'(1);

  // Rule table and lock; the lock is sampled before a same-cycle cfg_lock_i takes effect
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rules   <= RstRules;
      r_locked  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we_i && w_cfg_reject;
      if (cfg_we_i && !w_cfg_reject) begin
        r_rules[cfg_addr_i] <= cfg_rule_i;
      end
      if (cfg_lock_i) begin
        r_locked <= 1'b1;
      end
    end
  end

  // Single output register; a new accept may replace the result only when it is consumed
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_miss_cnt  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_idx   <= w_hit ? w_hit_idx : w_miss_idx;
      r_rsp_hit   <= w_hit;
      r_rsp_err   <= !w_hit && !EnDefault;
      if (!w_hit) begin
        r_miss_cnt <= w_miss_cnt_nxt;
      end
    end else if (lookup.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cfg_err_o        = r_cfg_err;
  assign locked_o         = r_locked;
  assign miss_cnt_o       = r_miss_cnt;
  assign lookup.req_ready = w_req_ready;
  assign lookup.rsp_valid = r_rsp_valid;
  assign lookup.rsp_idx   = r_rsp_idx;
  assign lookup.rsp_hit   = r_rsp_hit;
  assign lookup.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_soc_addr_map_cfg.sv
// Directed bench for soc_addr_map_cfg: a decode-error instance plus a default-route instance on the same inputs.
module tb_soc_addr_map_cfg;
  import soc_addr_map_cfg_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  rule_t           cfg_rule;
  logic            cfg_lock;
  logic            cfg_err, cfg_err_def;
  logic            locked, locked_def;
  logic [31:0]     miss_cnt, miss_cnt_def;
  int              n_vec = 0;
  int              n_err = 0;

  soc_addr_map_cfg_if bus ();
  soc_addr_map_cfg_if bus_def ();

  assign bus_def.req_valid = bus.req_valid;
  assign bus_def.req_addr  = bus.req_addr;
  assign bus_def.rsp_ready = bus.rsp_ready;

  always #5 clk = ~clk;

  soc_addr_map_cfg #(
    .EnDefault (1'b0),
    .RstRules  (RstRulesDefault)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_rule_i (cfg_rule),
    .cfg_lock_i (cfg_lock),
    .cfg_err_o  (cfg_err),
    .locked_o   (locked),
    .miss_cnt_o (miss_cnt),
    .lookup     (bus.slave)
  );

  soc_addr_map_cfg #(
    .EnDefault  (1'b1),
    .DefaultIdx (7),
    .RstRules   (RstRulesDefault)
  ) dut_def (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_rule_i (cfg_rule),
    .cfg_lock_i (cfg_lock),
    .cfg_err_o  (cfg_err_def),
    .locked_o   (locked_def),
    .miss_cnt_o (miss_cnt_def),
    .lookup     (bus_def.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the full response of the decode-error instance
  task automatic chk_rsp(input string tag, input logic v, input logic [3:0] idx,
                         input logic hit, input logic err);
    chk({tag, ".valid"}, 64'(bus.rsp_valid), 64'(v));
    chk({tag, ".idx"},   64'(bus.rsp_idx),   64'(idx));
    chk({tag, ".hit"},   64'(bus.rsp_hit),   64'(hit));
    chk({tag, ".err"},   64'(bus.rsp_err),   64'(err));
  endtask

  function automatic rule_t mk(input logic en, input logic [63:0] base,
                               input logic [63:0] len, input logic [3:0] idx);
    rule_t r;
    r.en   = en;
    r.base = base;
    r.len  = len;
    r.idx  = idx;
    return r;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input rule_t r, input logic lock);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_rule = r;
    cfg_lock = lock;
    tick();
    cfg_we   = 1'b0;
    cfg_lock = 1'b0;
  endtask

  task automatic req(input logic [63:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_rule      = '0;
    cfg_lock      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk_rsp("rst", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst.locked",   64'(locked),   64'd0);
    chk("rst.cfg_err",  64'(cfg_err),  64'd0);
    chk("rst.miss_cnt", 64'(miss_cnt), 64'd0);
    chk("rst.ready",    64'(bus.req_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Reset map, back-to-back lookups
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h8000_0000;
    chk("map.pre_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk_rsp("map.dram0", 1'b1, 4'd1, 1'b1, 1'b0);
    bus.req_addr = 64'h8000_0FFF;
    tick();
    chk_rsp("map.dram1", 1'b1, 4'd1, 1'b1, 1'b0);
    bus.req_addr = 64'h1000_0000;
    tick();
    chk_rsp("map.uart", 1'b1, 4'd2, 1'b1, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    chk("map.drain", 64'(bus.rsp_valid), 64'd0);

    // Boundaries of [0x1000, 0x2000) in entry 4
    cfg_write(4'd4, mk(1'b1, 64'h1000, 64'h1000, 4'd4), 1'b0);
    req(64'h0FFF);
    chk_rsp("bnd.below", 1'b1, 4'd0, 1'b0, 1'b1);
    chk("bnd.below.cnt", 64'(miss_cnt), 64'd1);
    chk("bnd.below.def_idx", 64'(bus_def.rsp_idx), 64'd7);
    chk("bnd.below.def_err", 64'(bus_def.rsp_err), 64'd0);
    chk("bnd.below.def_hit", 64'(bus_def.rsp_hit), 64'd0);
    req(64'h1000);
    chk_rsp("bnd.base", 1'b1, 4'd4, 1'b1, 1'b0);
    req(64'h1FFF);
    chk_rsp("bnd.last", 1'b1, 4'd4, 1'b1, 1'b0);
    req(64'h2000);
    chk_rsp("bnd.end", 1'b1, 4'd0, 1'b0, 1'b1);
    chk("bnd.end.cnt", 64'(miss_cnt), 64'd2);

    // Rule ending exactly at 2^64
    cfg_write(4'd5, mk(1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'd6), 1'b0);
    req(64'hFFFF_FFFF_FFFF_FFFF);
    chk_rsp("top.hit", 1'b1, 4'd6, 1'b1, 1'b0);

    // Slave index out of range never matches
    cfg_write(4'd7, mk(1'b1, 64'h4000_0000, 64'h100, 4'd12), 1'b0);
    req(64'h4000_0000);
    chk_rsp("badidx", 1'b1, 4'd0, 1'b0, 1'b1);
    chk("badidx.cnt", 64'(miss_cnt), 64'd3);

    // Out-of-range config address is rejected
    cfg_write(4'd12, mk(1'b1, 64'h0, 64'h10, 4'd1), 1'b0);
    chk("oor.err", 64'(cfg_err), 64'd1);
    tick();
    chk("oor.err_clr", 64'(cfg_err), 64'd0);

    // Overlap priority; a same-cycle write leaves the lookup on the old table
    cfg_write(4'd0, mk(1'b1, 64'h0, 64'h10000, 4'd3), 1'b0);
    cfg_write(4'd1, mk(1'b1, 64'h8000, 64'h10000, 4'd5), 1'b0);
    req(64'h9000);
    chk_rsp("ovl.r0", 1'b1, 4'd3, 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h9000;
    cfg_write(4'd0, mk(1'b0, 64'h0, 64'h10000, 4'd3), 1'b0);
    chk_rsp("ovl.same_cycle", 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    chk_rsp("ovl.r1", 1'b1, 4'd5, 1'b1, 1'b0);

    // Backpressure: hold the 0x9000 result for three cycles
    bus.rsp_ready = 1'b0;
    bus.req_addr  = 64'h1000;
    #1;
    chk("bp.ready0", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp("bp.hold", 1'b1, 4'd5, 1'b1, 1'b0);
      chk("bp.ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp.ready1", 64'(bus.req_ready), 64'd1);
    tick();
    chk_rsp("bp.rel0", 1'b1, 4'd4, 1'b1, 1'b0);
    bus.req_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk_rsp("bp.rel1", 1'b1, 4'd6, 1'b1, 1'b0);
    bus.req_addr = 64'h0200_0000;
    tick();
    chk_rsp("bp.rel2", 1'b1, 4'd3, 1'b1, 1'b0);
    bus.req_valid = 1'b0;
    tick();

    // Write together with lock is applied, later writes are rejected
    cfg_write(4'd6, mk(1'b1, 64'h3000_0000, 64'h100, 4'd8), 1'b1);
    chk("lock.set", 64'(locked), 64'd1);
    chk("lock.wr_ok", 64'(cfg_err), 64'd0);
    req(64'h3000_0000);
    chk_rsp("lock.same_cycle_wr", 1'b1, 4'd8, 1'b1, 1'b0);
    cfg_write(4'd2, mk(1'b1, 64'h0200_0000, 64'h10000, 4'd9), 1'b0);
    chk("lock.err", 64'(cfg_err), 64'd1);
    tick();
    chk("lock.err_pulse", 64'(cfg_err), 64'd0);
    chk("lock.hold", 64'(locked), 64'd1);
    req(64'h0200_0000);
    chk_rsp("lock.unchanged", 1'b1, 4'd3, 1'b1, 1'b0);

    // Further misses keep counting
    req(64'h5000_0000);
    chk_rsp("miss.err", 1'b1, 4'd0, 1'b0, 1'b1);
    chk("miss.cnt4", 64'(miss_cnt), 64'd4);
    chk("miss.def_idx", 64'(bus_def.rsp_idx), 64'd7);

    // Saturation from near the top of the counter
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h5000_0000;
    force dut.w_miss_cnt_nxt = 32'hFFFF_FFFE;
    tick();
    release dut.w_miss_cnt_nxt;
    chk("sat.fe", 64'(miss_cnt), 64'hFFFF_FFFE);
    tick();
    chk("sat.ff", 64'(miss_cnt), 64'hFFFF_FFFF);
    tick();
    chk("sat.hold", 64'(miss_cnt), 64'hFFFF_FFFF);
    bus.req_valid = 1'b0;
    tick();

    // Reset while a result is stalled
    bus.rsp_ready = 1'b0;
    req(64'h1000);
    tick();
    chk("stall.valid", 64'(bus.rsp_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk_rsp("rst2", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst2.cnt",    64'(miss_cnt), 64'd0);
    chk("rst2.locked", 64'(locked),   64'd0);
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    req(64'h1000_0000);
    chk_rsp("rst2.map", 1'b1, 4'd2, 1'b1, 1'b0);
    req(64'h1000);
    chk_rsp("rst2.reload", 1'b1, 4'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
